rpn_op_sequencer: RTL and testbench
===================================

Name: rpn_op_sequencer

Overview:
Sequences the stack-calculator datapath for a full RPN operation: push SW operands, pop two operands into the ALU operand registers, start the ALU, wait for completion with a timeout, and push the result. It tracks stack occupancy itself and raises sticky overflow, underflow and timeout errors. It sits between the debounced-key front end and the stack/ALU datapath, and supersedes the single-step push/start control.

Parameters:
DEPTH, 8, stack capacity in entries
CNT_W, 4, occupancy counter width; must hold 0..DEPTH
TIMEOUT, 255, maximum WAIT cycles before abort
TMR_W, 8, timer width; must hold 0..TIMEOUT

Ports:
Clk  in  1  system clock; the only clock
Reset  in  1  synchronous, active-high reset
key_push  in  1  one-cycle pulse: push SW[7:0] onto the stack
key_op  in  1  one-cycle pulse: execute the operation SW[2:0]
SW  in  8  switch inputs; the stack data mux carries the data path, SW[2:0] is the opcode
clr_err  in  1  one-cycle pulse: clear all error flags
ula_pronto  in  1  ALU done, level
pilha_empilha  out  1  stack push enable
pilha_desempilha  out  1  stack pop enable; the stack top is valid combinationally in the same cycle
pilha_sel_res  out  1  stack data mux: 0 selects SW, 1 selects the ALU result
opA_load  out  1  capture the stack top into operand A register
opB_load  out  1  capture the stack top into operand B register
ula_inicia  out  1  ALU start pulse
ula_op_code  out  3  ALU operation select
ocupado  out  1  high in every state except IDLE
nivel  out  CNT_W  current stack occupancy
err_overflow  out  1  sticky error flag
err_underflow  out  1  sticky error flag
err_timeout  out  1  sticky error flag

Behaviour:
- All registers update on the rising edge of Clk. Reset is synchronous and active-high, and takes priority over everything, including mid-operation.
- Reset values: state=IDLE, nivel=0, timer=0, latched op=0, all error flags=0. All strobes are 0 and ula_op_code=0.
- State encoding:
  - IDLE=000
  - PUSH_SW=001
  - POP_B=010
  - POP_A=011
  - START=100
  - WAIT=101
  - PUSH_RES=110
  - 111 is unused and returns to IDLE.
- Outputs are Moore-decoded from the state, except error setting, which happens on the transition edge.
- IDLE:
  - key_op has priority when both keys are high in the same cycle.
  - key_op with nivel<2: set err_underflow, stay in IDLE.
  - key_op otherwise: latch SW[2:0] into op, go to POP_B.
  - key_push with nivel==DEPTH: set err_overflow, stay in IDLE.
  - key_push otherwise: go to PUSH_SW.
  - Keys arriving in any other state are ignored; there is no queuing.
- PUSH_SW: pilha_empilha=1, pilha_sel_res=0; nivel+1; next state IDLE.
- POP_B: pilha_desempilha=1, opB_load=1; nivel-1; next state POP_A. B is the top of stack, i.e. the last value pushed.
- POP_A: pilha_desempilha=1, opA_load=1; nivel-1; timer cleared; next state START.
- START: ula_inicia=1 for exactly one cycle, ula_op_code=op; next state WAIT.
- WAIT:
  - ula_op_code=op is held and the timer increments every cycle.
  - ula_pronto=1: go to PUSH_RES. This is checked first, so pronto on the same cycle the timer hits TIMEOUT still succeeds.
  - Otherwise, timer==TIMEOUT-1: set err_timeout, go to IDLE. The operands are discarded and nivel stays reduced by 2.
- PUSH_RES: pilha_empilha=1, pilha_sel_res=1; nivel+1; next state IDLE.
- ula_op_code is 0 in every state other than START and WAIT.
- Minimum operation latency: key_op to result push is 5 cycles when pronto is already high in the first WAIT cycle.
- PUSH_RES never overflows, because two pops precede it.
- nivel never wraps; the guards above prevent it.
- Error flags are sticky and do not block operation.
  - clr_err clears all three flags.
  - If clr_err and a set condition coincide in the same cycle, the set wins.
- ocupado=0 only in IDLE.

Test Plan:
- Reset, push 8'h05, then push 8'h03 → one pilha_empilha pulse each with sel=0; nivel=2; ocupado high for 1 cycle per push.
- From nivel=2, key_op with SW[2:0]=3'b001 and ula_pronto high 3 cycles after START → pops in POP_B then POP_A; one ula_inicia pulse with op_code=001; op_code held through WAIT; push with sel_res=1; nivel=1; op_code returns to 0 in IDLE.
- Push 9 times → the first 8 pushes succeed; the 9th sets err_overflow; nivel stays 8 with no push strobe; a clr_err pulse clears the flag.
- key_op with nivel=1 → err_underflow=1; no pop or start strobes; nivel=1.
- key_op with ula_pronto held low → err_timeout asserts after TIMEOUT WAIT cycles; state returns to IDLE; nivel drops by 2; no result push.
- key_push and key_op in the same cycle with nivel=3 → the operation sequence runs and the push is dropped. Separately, assert Reset while in WAIT → next cycle is IDLE with nivel=0 and all flags 0.

Source files
------------

// File: rtl/rpn_op_sequencer.sv
// rpn_op_sequencer
//   Control sequencer for the RPN stack calculator. A key_push pulse pushes
//   SW onto the stack. A key_op pulse runs the full operation: it pops B and
//   then A into the ALU operand registers, starts the ALU, waits for
//   ula_pronto with a timeout, and pushes the result. The block keeps its own
//   count of stack occupancy and raises sticky overflow, underflow and
//   timeout flags.
//
// Ports
//   Clk, Reset          clock; synchronous active-high reset
//   key_push, key_op    one-cycle key pulses (key_op wins if both are high)
//   SW[7:0]             switches; SW[2:0] is the opcode latched on key_op
//   clr_err             one-cycle pulse that clears the error flags
//   ula_pronto          ALU done (level)
//   pilha_empilha       stack push enable
//   pilha_desempilha    stack pop enable
//   pilha_sel_res       stack data mux (0 = SW, 1 = ALU result)
//   opA_load, opB_load  operand register capture strobes
//   ula_inicia          ALU start pulse
//   ula_op_code         ALU operation, driven in START and WAIT only
//   ocupado             high whenever the sequencer is not in IDLE
//   nivel               current stack occupancy
//   err_overflow, err_underflow, err_timeout   sticky error flags
module rpn_op_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMR_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             key_push,
  input  logic             key_op,
  input  logic [7:0]       SW,
  input  logic             clr_err,
  input  logic             ula_pronto,
  output logic             pilha_empilha,
  output logic             pilha_desempilha,
  output logic             pilha_sel_res,
  output logic             opA_load,
  output logic             opB_load,
  output logic             ula_inicia,
  output logic [2:0]       ula_op_code,
  output logic             ocupado,
  output logic [CNT_W-1:0] nivel,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_PUSH_SW  = 3'b001,
    S_POP_B    = 3'b010,
    S_POP_A    = 3'b011,
    S_START    = 3'b100,
    S_WAIT     = 3'b101,
    S_PUSH_RES = 3'b110,
    S_UNUSED   = 3'b111
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   nivel_q, nivel_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [2:0]         op_q, op_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_unf_q, err_unf_d;
  logic               err_tmo_q, err_tmo_d;
  logic               set_ovf, set_unf, set_tmo;

  // SW[7:3] only feeds the stack data mux outside this block.
  logic unused_sw_hi;
  assign unused_sw_hi = ^SW[7:3];

  // Next state, occupancy, timer and error-set conditions
  always_comb begin
    state_d = state_q;
    nivel_d = nivel_q;
    timer_d = timer_q;
    op_d    = op_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    set_tmo = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_op) begin
          if (nivel_q < CNT_W'(2)) begin
            set_unf = 1'b1;
          end else begin
            op_d    = SW[2:0];
            state_d = S_POP_B;
          end
        end else if (key_push) begin
          if (nivel_q == CNT_W'(DEPTH)) begin
            set_ovf = 1'b1;
          end else begin
            state_d = S_PUSH_SW;
          end
        end
      end
      S_PUSH_SW: begin
        nivel_d = nivel_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      S_POP_B: begin
        nivel_d = nivel_q - CNT_W'(1);
        state_d = S_POP_A;
      end
      S_POP_A: begin
        nivel_d = nivel_q - CNT_W'(1);
        timer_d = '0;
        state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // pronto is checked before the timeout so a late done still succeeds
        if (ula_pronto) begin
          state_d = S_PUSH_RES;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          set_tmo = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PUSH_RES: begin
        nivel_d = nivel_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // a set condition wins over a coincident clear
    err_ovf_d = set_ovf | (err_ovf_q & ~clr_err);
    err_unf_d = set_unf | (err_unf_q & ~clr_err);
    err_tmo_d = set_tmo | (err_tmo_q & ~clr_err);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      nivel_q   <= '0;
      timer_q   <= '0;
      op_q      <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nivel_q   <= nivel_d;
      timer_q   <= timer_d;
      op_q      <= op_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  // Moore output decode
  always_comb begin
    pilha_empilha    = 1'b0;
    pilha_desempilha = 1'b0;
    pilha_sel_res    = 1'b0;
    opA_load         = 1'b0;
    opB_load         = 1'b0;
    ula_inicia       = 1'b0;
    ula_op_code      = '0;
    ocupado          = (state_q != S_IDLE);
    case (state_q)
      S_PUSH_SW: begin
        pilha_empilha = 1'b1;
      end
      S_POP_B: begin
        pilha_desempilha = 1'b1;
        opB_load         = 1'b1;
      end
      S_POP_A: begin
        pilha_desempilha = 1'b1;
        opA_load         = 1'b1;
      end
      S_START: begin
        ula_inicia  = 1'b1;
        ula_op_code = op_q;
      end
      S_WAIT: begin
        ula_op_code = op_q;
      end
      S_PUSH_RES: begin
        pilha_empilha = 1'b1;
        pilha_sel_res = 1'b1;
      end
      default: ;
    endcase
  end

  assign nivel         = nivel_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign err_timeout   = err_tmo_q;

endmodule

// File: tb/tb_rpn_op_sequencer.sv
// tb_rpn_op_sequencer
//   Scoreboard bench for rpn_op_sequencer. Each stimulus task predicts the
//   strobe events the sequencer should emit and queues them; a negedge
//   monitor pops one entry per observed strobe cycle. Occupancy, flags, busy
//   time and opcode hold time are compared against a small reference model.
module tb_rpn_op_sequencer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned TMR_W   = 8;

  logic             Clk, Reset;
  logic             key_push, key_op, clr_err, ula_pronto;
  logic [7:0]       SW;
  logic             pilha_empilha, pilha_desempilha, pilha_sel_res;
  logic             opA_load, opB_load, ula_inicia, ocupado;
  logic [2:0]       ula_op_code;
  logic [CNT_W-1:0] nivel;
  logic             err_overflow, err_underflow, err_timeout;

  rpn_op_sequencer #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .key_push        (key_push),
    .key_op          (key_op),
    .SW              (SW),
    .clr_err         (clr_err),
    .ula_pronto      (ula_pronto),
    .pilha_empilha   (pilha_empilha),
    .pilha_desempilha(pilha_desempilha),
    .pilha_sel_res   (pilha_sel_res),
    .opA_load        (opA_load),
    .opB_load        (opB_load),
    .ula_inicia      (ula_inicia),
    .ula_op_code     (ula_op_code),
    .ocupado         (ocupado),
    .nivel           (nivel),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow),
    .err_timeout     (err_timeout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe event: {empilha, desempilha, sel_res, opA, opB, inicia, op_code}
  localparam logic [8:0] EV_PUSH_SW  = 9'b1_0_0_0_0_0_000;
  localparam logic [8:0] EV_POP_B    = 9'b0_1_0_0_1_0_000;
  localparam logic [8:0] EV_POP_A    = 9'b0_1_0_1_0_0_000;
  localparam logic [8:0] EV_PUSH_RES = 9'b1_0_1_0_0_0_000;

  logic [8:0] exp_q[$];

  always @(negedge Clk) begin
    logic [8:0] obs;
    obs = {pilha_empilha, pilha_desempilha, pilha_sel_res, opA_load, opB_load,
           ula_inicia, ula_op_code};
    if (|obs[8:3]) begin
      if (exp_q.size() == 0) check_eq("unexpected_strobe", 32'(obs), 32'd0);
      else check_eq("strobe_event", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  // ALU responder: raise pronto pronto_dly negedges after the start pulse;
  // a negative delay models an ALU that never answers.
  int pronto_dly = 0;
  initial begin
    ula_pronto = 1'b0;
    forever begin
      @(negedge Clk);
      if (ula_inicia && pronto_dly >= 0) begin
        repeat (pronto_dly) @(negedge Clk);
        ula_pronto = 1'b1;
        repeat (2) @(negedge Clk);
        ula_pronto = 1'b0;
      end
    end
  end

  // reference model
  int unsigned nivel_m;
  logic        ovf_m, unf_m, tmo_m;

  task automatic check_model(input string tag);
    check_eq({tag, "_nivel"}, 32'(nivel), 32'(nivel_m));
    check_eq({tag, "_flags"}, {29'd0, err_overflow, err_underflow, err_timeout},
             {29'd0, ovf_m, unf_m, tmo_m});
    check_eq({tag, "_idle_opcode"}, 32'(ula_op_code), 32'd0);
  endtask

  task automatic pulse(input logic p, input logic o, input logic c, input logic [7:0] sw);
    SW = sw; key_push = p; key_op = o; clr_err = c;
    @(posedge Clk); #1;
    key_push = 1'b0; key_op = 1'b0; clr_err = 1'b0;
  endtask

  // counts busy cycles and opcode-driven cycles until IDLE, bounded
  task automatic wait_idle(input logic [2:0] op, output int busy, output int opc,
                           output int bad_opc);
    busy = 0; opc = 0; bad_opc = 0;
    while (ocupado && busy < 400) begin
      busy++;
      if (ula_op_code != 3'd0) begin
        opc++;
        if (ula_op_code != op) bad_opc++;
      end
      @(posedge Clk); #1;
    end
    if (busy >= 400) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_push(input logic [7:0] d, input string tag);
    int busy, opc, bad_opc;
    int exp_busy;
    if (nivel_m == DEPTH) begin
      ovf_m = 1'b1; exp_busy = 0;
    end else begin
      exp_q.push_back(EV_PUSH_SW); nivel_m++; exp_busy = 1;
    end
    pulse(1'b1, 1'b0, 1'b0, d);
    wait_idle(3'd0, busy, opc, bad_opc);
    check_eq({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check_model(tag);
  endtask

  task automatic do_op(input logic [2:0] op, input int dly, input logic both, input string tag);
    int busy, opc, bad_opc;
    int exp_busy, exp_opc, w;
    pronto_dly = dly;
    w = (dly < 0) ? int'(TIMEOUT) : ((dly < 1) ? 1 : dly);
    if (nivel_m < 2) begin
      unf_m = 1'b1; exp_busy = 0; exp_opc = 0;
    end else begin
      exp_q.push_back(EV_POP_B);
      exp_q.push_back(EV_POP_A);
      exp_q.push_back({6'b000001, op});
      exp_busy = 3 + w; exp_opc = 1 + w;
      if (dly >= 0) begin
        exp_q.push_back(EV_PUSH_RES); exp_busy++; nivel_m = nivel_m - 1;
      end else begin
        tmo_m = 1'b1; nivel_m = nivel_m - 2;
      end
    end
    pulse(both, 1'b1, 1'b0, {5'b10100, op});
    wait_idle(op, busy, opc, bad_opc);
    check_eq({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check_eq({tag, "_opcode_cycles"}, 32'(opc), 32'(exp_opc));
    check_eq({tag, "_opcode_value"}, 32'(bad_opc), 32'd0);
    check_model(tag);
  endtask

  task automatic do_clr(input logic with_push, input string tag);
    if (with_push && nivel_m == DEPTH) ovf_m = 1'b1;
    else begin ovf_m = 1'b0; end
    unf_m = 1'b0; tmo_m = 1'b0;
    pulse(with_push, 1'b0, 1'b1, 8'h11);
    check_model(tag);
  endtask

  initial begin
    Reset = 1'b1; key_push = 1'b0; key_op = 1'b0; clr_err = 1'b0; SW = '0;
    nivel_m = 0; ovf_m = 1'b0; unf_m = 1'b0; tmo_m = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check_eq("rst_ocupado", 32'(ocupado), 32'd0);
    check_eq("rst_strobes", {26'd0, pilha_empilha, pilha_desempilha, pilha_sel_res,
             opA_load, opB_load, ula_inicia}, 32'd0);
    check_model("rst");

    do_push(8'h05, "push05");
    do_push(8'h03, "push03");
    do_op(3'b001, 3, 1'b0, "op_add");
    do_op(3'b010, 0, 1'b0, "op_underflow");

    for (int i = 0; i < 8; i++) do_push(8'(i + 8'h20), "push_fill");
    check_eq("fill_nivel8", 32'(nivel), 32'(DEPTH));
    do_clr(1'b0, "clr_ovf");
    do_clr(1'b1, "clr_vs_set");
    do_clr(1'b0, "clr_again");

    do_op(3'b011, -1, 1'b0, "op_timeout");
    do_op(3'b100, 0, 1'b0, "op_dly0");
    do_op(3'b101, 1, 1'b0, "op_dly1");
    do_op(3'b110, 2, 1'b0, "op_dly2");
    check_eq("both_pre_nivel", 32'(nivel), 32'd3);
    do_op(3'b111, 2, 1'b1, "op_both_keys");

    // reset while waiting on a silent ALU
    pronto_dly = -1;
    exp_q.push_back(EV_POP_B);
    exp_q.push_back(EV_POP_A);
    exp_q.push_back({6'b000001, 3'b010});
    pulse(1'b0, 1'b1, 1'b0, 8'h02);
    repeat (8) begin @(posedge Clk); #1; end
    check_eq("wait_busy", 32'(ocupado), 32'd1);
    check_eq("wait_opcode", 32'(ula_op_code), 32'd2);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    nivel_m = 0; ovf_m = 1'b0; unf_m = 1'b0; tmo_m = 1'b0;
    check_eq("rst_wait_ocupado", 32'(ocupado), 32'd0);
    check_model("rst_wait");

    repeat (3) @(posedge Clk);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
